// File: rtl/fa_share_arb.sv
// rtl/fa_share_arb.sv - round-robin sharing of one pipelined FP32 adder among N requesters
// Optional build macro FA_SHARE_ARB_SUB_EN adds req_sub (sign-flip of operand B for A-B).
module fa_share_arb #(
    parameter int N   = 4,
    parameter int LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [32*N-1:0] req_a,
    input  logic [32*N-1:0] req_b,
`ifdef FA_SHARE_ARB_SUB_EN
    input  logic [N-1:0]    req_sub,
`endif
    output logic [N-1:0]    req_ready,
    output logic [31:0]     fa_a,
    output logic [31:0]     fa_b,
    output logic            fa_issue,
    input  logic [31:0]     fa_sum,
    input  logic            fa_done,
    output logic [N-1:0]    rsp_valid,
    output logic [31:0]     rsp_sum,
    output logic            err
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;
    logic [31:0]   b_next;
    logic [LAT:0]  tag_v;
    logic [IW-1:0] tag_idx [0:LAT];

    // Search ptr, ptr+1, ... modulo N; first pending request wins.
    always_comb begin
        logic [IW:0] s;
        s         = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr} + (IW+1)'(k);
            if (s >= (IW+1)'(N)) begin
                s = s - (IW+1)'(N);
            end
            if (!gnt_any && req_valid[s[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = s[IW-1:0];
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

`ifdef FA_SHARE_ARB_SUB_EN
    logic sel_sub;
`endif

    always_comb begin
        sel_a = '0;
        sel_b = '0;
`ifdef FA_SHARE_ARB_SUB_EN
        sel_sub = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == IW'(k)) begin
                sel_a = req_a[k*32 +: 32];
                sel_b = req_b[k*32 +: 32];
`ifdef FA_SHARE_ARB_SUB_EN
                sel_sub = req_sub[k];
`endif
            end
        end
    end

`ifdef FA_SHARE_ARB_SUB_EN
    // Subtraction is a pure sign flip of B, NaN payloads included.
    assign b_next = sel_sub ? {~sel_b[31], sel_b[30:0]} : sel_b;
`else
    assign b_next = sel_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            fa_a      <= '0;
            fa_b      <= '0;
            fa_issue  <= 1'b0;
            tag_v     <= '0;
            rsp_valid <= '0;
            rsp_sum   <= '0;
            err       <= 1'b0;
            for (int k = 0; k <= LAT; k++) begin
                tag_idx[k] <= '0;
            end
        end else begin
            fa_issue <= gnt_any;
            if (gnt_any) begin
                fa_a <= sel_a;
                fa_b <= b_next;
                ptr  <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
            end

            // Owner tags travel alongside the adder so the last stage lines up with fa_done.
            tag_v      <= {tag_v[LAT-1:0], gnt_any};
            tag_idx[0] <= gnt_idx;
            for (int k = 1; k <= LAT; k++) begin
                tag_idx[k] <= tag_idx[k-1];
            end

            rsp_valid <= '0;
            if (fa_done && tag_v[LAT]) begin
                rsp_valid[tag_idx[LAT]] <= 1'b1;
                rsp_sum                 <= fa_sum;
            end

            if (fa_done != tag_v[LAT]) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fa_share_arb.sv
// tb/tb_fa_share_arb.sv - randomized and directed bench for fa_share_arb with a queue-based reference model
// Build with FA_SHARE_ARB_SUB_EN defined to cover the subtract option.
module tb_fa_share_arb;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
`ifdef FA_SHARE_ARB_SUB_EN
    logic [N-1:0]    req_sub;
`endif
    logic [N-1:0]    req_ready;
    logic [31:0]     fa_a;
    logic [31:0]     fa_b;
    logic            fa_issue;
    logic [31:0]     fa_sum;
    logic            fa_done;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_sum;
    logic            err;

    always #5 clk = ~clk;

    fa_share_arb #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
`ifdef FA_SHARE_ARB_SUB_EN
        .req_sub(req_sub),
`endif
        .req_ready(req_ready),
        .fa_a(fa_a), .fa_b(fa_b), .fa_issue(fa_issue),
        .fa_sum(fa_sum), .fa_done(fa_done),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .err(err)
    );

    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:0] == 31'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] int_to_f(input int n);
        return r2f($itor(n));
    endfunction

    // Adder stand-in: fixed LAT pipeline, reset together with the arbiter.
    logic        pv [LAT];
    logic [31:0] pa [LAT];
    logic [31:0] pb [LAT];
    logic        inj;
    assign fa_done = pv[LAT-1] | inj;
    assign fa_sum  = fadd(pa[LAT-1], pb[LAT-1]);

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) pv[k] <= 1'b0;
        end else begin
            pv[0] <= fa_issue;
            pa[0] <= fa_a;
            pb[0] <= fa_b;
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic armed = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Reference model: pending results listed by the cycle their response must appear.
    typedef struct {
        int          due;
        int          idx;
        logic [31:0] sum;
    } item_t;
    item_t q[$];

    int          mptr     = 0;
    logic        exp_iss  = 1'b0;
    logic [31:0] exp_a    = 32'd0;
    logic [31:0] exp_b    = 32'd0;
    logic [N-1:0] exp_rsp = '0;
    logic [31:0] exp_sum  = 32'd0;
    logic        exp_err  = 1'b0;

    always @(negedge clk) begin : model
        int          g;
        int          j;
        logic [N-1:0] eg;
        logic        tag_last;
        logic [31:0] ga;
        logic [31:0] gb;
        item_t       it;

        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;

        if (armed) begin
            check("req_ready", 32'(req_ready), 32'(eg));
            check("fa_issue", 32'(fa_issue), 32'(exp_iss));
            check("fa_a", fa_a, exp_a);
            check("fa_b", fa_b, exp_b);
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            check("rsp_sum", rsp_sum, exp_sum);
            check("err", 32'(err), 32'(exp_err));
        end

        if (rst) begin
            mptr    = 0;
            exp_iss = 1'b0;
            exp_a   = 32'd0;
            exp_b   = 32'd0;
            exp_rsp = '0;
            exp_sum = 32'd0;
            exp_err = 1'b0;
            q.delete();
        end else begin
            tag_last = (q.size() > 0) && (q[0].due == cyc + 1);
            exp_rsp  = '0;
            if (tag_last) begin
                it = q.pop_front();
                if (fa_done) begin
                    exp_rsp[it.idx] = 1'b1;
                    exp_sum         = it.sum;
                end
            end
            if (fa_done != tag_last) exp_err = 1'b1;

            exp_iss = (g >= 0);
            if (g >= 0) begin
                ga = req_a[g*32 +: 32];
                gb = req_b[g*32 +: 32];
`ifdef FA_SHARE_ARB_SUB_EN
                if (req_sub[g]) gb[31] = ~gb[31];
`endif
                exp_a = ga;
                exp_b = gb;
                q.push_back('{cyc + LAT + 2, g, fadd(ga, gb)});
                mptr = (g + 1) % N;
            end
        end
        cyc++;
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [3:0] exp3 [6];
    logic [N-1:0] acc;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        inj       = 1'b0;
`ifdef FA_SHARE_ARB_SUB_EN
        req_sub   = '0;
`endif
        repeat (2) @(posedge clk);
        #1 armed = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_fa_issue", 32'(fa_issue), 32'd0);
        check("reset_rsp_sum", rsp_sum, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request from requester 2: 1.0 + 2.0
        set_req(2, 32'h3F80_0000, 32'h4000_0000);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("single_issue", 32'(fa_issue), 32'd1);
        check("single_fa_a", fa_a, 32'h3F80_0000);
        check("single_fa_b", fa_b, 32'h4000_0000);
        repeat (3) @(negedge clk);
        check("single_early_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'h4);
        check("single_rsp_sum", rsp_sum, 32'h4040_0000);

        // All four held valid: strict rotation from reset
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, int_to_f(10 * i + 1), int_to_f(i + 2));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rotation_grant", 32'(req_ready), 32'(1) << (k % 4));
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (LAT + 4) @(posedge clk);

        // Requester 1 always valid, requester 3 joins in cycle 2
        exp3[0] = 4'b0010; exp3[1] = 4'b0010; exp3[2] = 4'b1000;
        exp3[3] = 4'b0010; exp3[4] = 4'b1000; exp3[5] = 4'b0010;
        do_reset();
        set_req(1, int_to_f(5), int_to_f(7));
        set_req(3, int_to_f(100), int_to_f(200));
        req_valid = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) req_valid = 4'b1010;
            @(negedge clk);
            check("fair_grant", 32'(req_ready), 32'(exp3[k]));
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (LAT + 4) @(posedge clk);

        // Stray fa_done with empty tag pipeline
        do_reset();
        repeat (LAT + 3) @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        check("proto_err_set", 32'(err), 32'd1);
        check("proto_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("proto_err_sticky", 32'(err), 32'd1);
        do_reset();
        @(negedge clk);
        check("proto_err_cleared", 32'(err), 32'd0);

        // Reset one cycle after two accepts
        do_reset();
        set_req(0, int_to_f(3), int_to_f(4));
        set_req(1, int_to_f(6), int_to_f(8));
        req_valid = 4'b0011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_fa_issue", 32'(fa_issue), 32'd0);
        check("midrst_fa_a", fa_a, 32'd0);
        check("midrst_fa_b", fa_b, 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        repeat (LAT + 3) @(negedge clk);
        check("midrst_late_rsp", 32'(rsp_valid), 32'd0);
        check("midrst_late_err", 32'(err), 32'd0);

`ifdef FA_SHARE_ARB_SUB_EN
        // 3.0 - 1.0 via sign flip
        do_reset();
        set_req(0, 32'h4040_0000, 32'h3F80_0000);
        req_sub   = 4'b0001;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        req_sub   = '0;
        @(negedge clk);
        check("sub_fa_b", fa_b, 32'hBF80_0000);
        repeat (4) @(negedge clk);
        check("sub_rsp_sum", rsp_sum, 32'h4000_0000);
        check("sub_rsp_valid", 32'(rsp_valid), 32'h1);
`endif

        // Randomized traffic, requests held until accepted
        do_reset();
        acc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(2) != 0);
                    set_req(i, int_to_f(int'($urandom_range(1000))), int_to_f(int'($urandom_range(1000))));
`ifdef FA_SHARE_ARB_SUB_EN
                    req_sub[i] = $urandom_range(1) == 1;
`endif
                end
            end
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (LAT + 5) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
